// File: rtl/regfile_write_queue.sv
// regfile_write_queue: in-order write queue feeding the single register file write port; WB_MERGE_EN merges writes into the youngest entry
module regfile_write_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              md_valid,
  input  logic [ADDR_W-1:0] md_reg,
  input  logic [DATA_W-1:0] md_data,
  output logic              md_ready,
  output logic              regwrite,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic [31:0]       pending,
  input  logic [ADDR_W-1:0] byp_reg,
  output logic              byp_hit,
  output logic [DATA_W-1:0] byp_data
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [ADDR_W-1:0] ent_reg_q [DEPTH];
  logic [ADDR_W-1:0] ent_reg_d [DEPTH];
  logic [DATA_W-1:0] ent_data_q [DEPTH];
  logic [DATA_W-1:0] ent_data_d [DEPTH];
  logic [CW-1:0]     count_q, count_d, n;
  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [1:0]        in_v;
  logic [ADDR_W-1:0] in_r [2];
  logic [DATA_W-1:0] in_d [2];
  logic              mrg;
  assign md_ready   = count_q <= CW'(DEPTH - 2);
  assign in_v       = {md_valid && md_ready && md_reg != '0, wb_valid && wb_reg != '0};
  assign in_r       = '{wb_reg, md_reg};
  assign in_d       = '{wb_data, md_data};
  assign regwrite   = regwrite_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  // Pop the head into the port, compact the queue, then append wb before md (entry 0 is always the head)
  always_comb begin
    ent_reg_d    = ent_reg_q;
    ent_data_d   = ent_data_q;
    regwrite_d   = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    n            = count_q;
    mrg          = 1'b0;
    if (count_q != '0) begin
      regwrite_d   = 1'b1;
      write_reg_d  = ent_reg_q[0];
      write_data_d = ent_data_q[0];
      for (int i = 0; i < DEPTH - 1; i++) begin
        ent_reg_d[i]  = ent_reg_q[i+1];
        ent_data_d[i] = ent_data_q[i+1];
      end
      n = count_q - CW'(1);
    end
    for (int k = 0; k < 2; k++) begin
      mrg = 1'b0;
`ifdef WB_MERGE_EN
      for (int j = 0; j < DEPTH; j++) begin
        if (in_v[k] && CW'(j + 1) == n && ent_reg_d[j] == in_r[k]) begin
          ent_data_d[j] = in_d[k];
          mrg           = 1'b1;
        end
      end
`endif
      if (in_v[k] && !mrg) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (CW'(j) == n) begin
            ent_reg_d[j]  = in_r[k];
            ent_data_d[j] = in_d[k];
          end
        end
        n = n + CW'(1);
      end
    end
    count_d = n;
  end
  // Queue and port registers; reset discards everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_reg_q[i]  <= '0;
        ent_data_q[i] <= '0;
      end
      count_q      <= '0;
      regwrite_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      ent_reg_q    <= ent_reg_d;
      ent_data_q   <= ent_data_d;
      count_q      <= count_d;
      regwrite_q   <= regwrite_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end
  // Scoreboard and forwarding over the port and valid entries; later (younger) matches win
  always_comb begin
    pending  = '0;
    byp_hit  = 1'b0;
    byp_data = '0;
    if (regwrite_q) begin
      pending[write_reg_q] = 1'b1;
      if (write_reg_q == byp_reg) begin
        byp_hit  = 1'b1;
        byp_data = write_data_q;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        pending[ent_reg_q[i]] = 1'b1;
        if (ent_reg_q[i] == byp_reg) begin
          byp_hit  = 1'b1;
          byp_data = ent_data_q[i];
        end
      end
    end
    pending[0] = 1'b0;
    if (byp_reg == '0) begin
      byp_hit  = 1'b0;
      byp_data = '0;
    end
  end
endmodule

// File: doc/regfile_write_queue.md
Name: regfile_write_queue

Overview:
Write-side controller for the 32x32 register file, which has a single write port.
- Accepts writeback requests from the pipeline (WB stage) and from the multi-cycle mult/div unit (HI/LO-derived results).
- Queues requests in order and drives the register file write port (regwrite, write_reg, write_data) with at most one write per cycle.
- Exports a per-register pending scoreboard and a forwarding lookup for the hazard/forwarding logic.

Parameters:
DEPTH, 4, number of FIFO entries (minimum 2)
DATA_W, 32, write data width
ADDR_W, 5, register index width

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  asynchronous reset, active-low
wb_valid  input  1  pipeline writeback request; no backpressure, always accepted
wb_reg  input  ADDR_W  pipeline destination register
wb_data  input  DATA_W  pipeline write data
md_valid  input  1  mult/div writeback request
md_reg  input  ADDR_W  mult/div destination register
md_data  input  DATA_W  mult/div write data
md_ready  output  1  mult/div request accepted at this edge if md_valid=1
regwrite  output  1  register file write enable (registered)
write_reg  output  ADDR_W  register file write index (registered)
write_data  output  DATA_W  register file write data (registered)
pending  output  32  bit r=1 while any write to r is queued or on the port; bit 0 always 0
byp_reg  input  ADDR_W  forwarding lookup index
byp_hit  output  1  byp_reg!=0 and a write to byp_reg is queued or on the port
byp_data  output  DATA_W  data of the youngest matching write; 0 when byp_hit=0

Behaviour:
- Reset (async, rst_n=0): FIFO emptied, count=0, regwrite=0, write_reg=0, write_data=0. Consequently pending=0, byp_hit=0, md_ready=1. Queued writes are discarded and no write is issued after reset.
- Writes to register 0 are dropped at input: not enqueued and not counted. md_ready is still honoured for them.
- Pop: at each posedge with count>0 (state before the edge), the head moves into the output regs and regwrite=1. With count=0, regwrite=0 and write_reg/write_data hold their values.
- The register file samples on negedge, so the write completes mid-cycle.
- Push: wb accepted whenever wb_valid=1. md accepted when md_valid=1 and md_ready=1.
- md_ready = (count <= DEPTH-2), combinational from count.
- Same-edge wb and md: the wb entry is enqueued first (older).
- next_count = count - pop + push_wb + push_md.
- Overflow is impossible by construction: wb alone nets ≤0 when non-empty, and md is gated.
- An entry enqueued at edge N is popped no earlier than edge N+1. Minimum latency: request at edge N, regwrite high during cycle N+1→N+2.
- Ordering: strict FIFO. Multiple writes to the same register issue in arrival order; the final value is from the youngest.
- pending/byp are combinational over (valid FIFO entries ∪ output reg when regwrite=1).
- byp_data priority: youngest FIFO entry (nearest tail) > older entries > output reg.

Optional Feature:
Macro WB_MERGE_EN.
- Defined: an accepted write whose register equals the youngest valid FIFO entry's register overwrites that entry's data in place. No new slot is used and count is unchanged. Merge is not allowed into an entry being popped at the same edge.
- Same-edge wb+md to the same register: md merges into the wb entry.
- Not defined: every accepted write occupies its own slot and issues its own regwrite pulse.

Test Plan:
- Assert rst_n=0 → regwrite=0, write_reg=0, write_data=0, pending=0, byp_hit=0, md_ready=1.
- wb_valid, wb_reg=5, wb_data=0xDEADBEEF at edge N → regwrite=1, write_reg=5, write_data=0xDEADBEEF in cycle N+1 only; pending[5]=1 from N to N+2, then 0.
- wb_valid, wb_reg=0, wb_data=0x1234 → regwrite stays 0; pending stays 0; byp_reg=0 gives byp_hit=0.
- Same edge wb r3=1, md r3=2 (macro off) → regwrite r3=1, then r3=2 on consecutive cycles; byp_reg=3 gives byp_data=2 until the second write leaves the port. With WB_MERGE_EN → a single write r3=2.
- DEPTH=4, dual pushes every edge (wb r1..r6, md r11..r16) → md_ready deasserts at count=3. No write lost; port order is wb/md interleaved per edge; count never exceeds 4.
- Reset mid-operation with 3 entries queued and regwrite=1 → outputs 0 immediately on rst_n fall; no regwrite after rst_n rises; pending=0.
